cordic_phase_frontend: RTL and testbench

- Phase-domain front/back end wrapped around the 17-bit Q2.15 pipelined CORDIC sin/cos core.
- Upstream side:
  - NCO phase accumulator (unsigned 16-bit fraction of a turn).
  - Quadrant reduction to a residual angle in [-pi/4, pi/4).
  - Conversion of the residual to Q2.15 radians, driven onto the core's beta input.
- Downstream side:
  - Delays quadrant and valid tags by the core latency.
  - Applies swap/negate correction to the core's sin/cos, producing full-circle results with a valid strobe.

---
 rtl/cordic_phase_frontend.sv | 143 ++++++++++++++
 tb/tb_cordic_phase_frontend.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/cordic_phase_frontend.sv
// cordic_phase_frontend: phase-domain wrapper around a pipelined Q2.15 CORDIC
// sin/cos core.
//   Upstream:   NCO accumulator -> quadrant reduction -> residual angle in
//               Q2.15 radians, driven on beta_out.
//   Downstream: quadrant/valid tags delayed by CORDIC_LAT, then swap/negate
//               correction of the core sin/cos into full-circle outputs.
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   en                  advance accumulator and launch one sample
//   freq_word[15:0]     phase increment per enabled edge
//   phase_offset[15:0]  phase offset added after the accumulator
//   beta_out[16:0]      residual angle to the core (registered)
//   core_sin/core_cos   core results, CORDIC_LAT edges after beta capture
//   sin_out/cos_out     full-circle results (registered)
//   out_valid           sin_out/cos_out carry a launched sample
// Optional build macro: CORDIC_PHASE_FRONTEND_DITHER_EN adds LFSR phase dither.
module cordic_phase_frontend #(
    parameter int unsigned CORDIC_LAT  = 7,
    parameter int unsigned DITHER_BITS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [15:0]        freq_word,
    input  logic [15:0]        phase_offset,
    output logic signed [16:0] beta_out,
    input  logic signed [16:0] core_sin,
    input  logic signed [16:0] core_cos,
    output logic signed [16:0] sin_out,
    output logic signed [16:0] cos_out,
    output logic               out_valid
);

    localparam int unsigned PH_W   = 16;
    localparam int unsigned D_W    = 17;
    localparam int unsigned R_W    = 15;
    localparam int unsigned PROD_W = 30;
    localparam int unsigned LAST   = CORDIC_LAT - 1;

    if (DITHER_BITS < 1 || DITHER_BITS > 8) begin : g_bad_dither
        $error("DITHER_BITS must be in 1..8");
    end

    // Stage A: phase accumulator
    logic [PH_W-1:0] acc_q, acc_d;
    logic            vld_a_q;

    always_comb begin
        acc_d = acc_q;
        if (en) acc_d = acc_q + freq_word;
    end

    // Stage B: offset, optional dither, quadrant split, residual scaling
    logic [PH_W-1:0]          p_c, s_c;
    logic signed [R_W-1:0]    r_c;
    logic signed [PROD_W-1:0] prod_c;
    logic signed [D_W-1:0]    beta_d;
    logic [1:0]               q_b_q;
    logic                     vld_b_q;

`ifdef CORDIC_PHASE_FRONTEND_DITHER_EN
    // Fibonacci LFSR, taps 16,14,13,11, stepped once per launched sample
    logic [PH_W-1:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (en) lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    always_ff @(posedge clk) begin
        if (rst) lfsr_q <= 16'hACE1;
        else     lfsr_q <= lfsr_d;
    end

    assign p_c = acc_q + phase_offset + PH_W'(lfsr_q[DITHER_BITS-1:0]);
`else
    assign p_c = acc_q + phase_offset;
`endif

    // Rotating by an eighth turn makes the top two bits the nearest quadrant
    // and leaves a residual centred on zero.
    always_comb begin
        s_c    = p_c + 16'h2000;
        r_c    = $signed({1'b0, s_c[13:0]}) - 15'sd8192;
        prod_c = PROD_W'(r_c) * 30'sd25736;
        beta_d = D_W'(prod_c >>> 13);
    end

    // Tag delay lines aligned with the core pipeline
    logic [1:0] qd_q [CORDIC_LAT];
    logic       vd_q [CORDIC_LAT];
    logic [1:0] qd;

    assign qd = qd_q[LAST];

    // Output stage: map the first-quadrant result back onto the full circle
    logic signed [D_W-1:0] sin_d, cos_d;

    always_comb begin
        sin_d = core_sin;
        cos_d = core_cos;
        case (qd)
            2'd0: begin sin_d = core_sin;  cos_d = core_cos;  end
            2'd1: begin sin_d = core_cos;  cos_d = -core_sin; end
            2'd2: begin sin_d = -core_sin; cos_d = -core_cos; end
            2'd3: begin sin_d = -core_cos; cos_d = core_sin;  end
            default: begin sin_d = core_sin; cos_d = core_cos; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            vld_a_q   <= 1'b0;
            beta_out  <= '0;
            q_b_q     <= '0;
            vld_b_q   <= 1'b0;
            for (int unsigned i = 0; i < CORDIC_LAT; i++) begin
                qd_q[i] <= '0;
                vd_q[i] <= 1'b0;
            end
            sin_out   <= '0;
            cos_out   <= '0;
            out_valid <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            vld_a_q  <= en;
            beta_out <= beta_d;
            q_b_q    <= s_c[15:14];
            vld_b_q  <= vld_a_q;
            qd_q[0]  <= q_b_q;
            vd_q[0]  <= vld_b_q;
            for (int unsigned i = 1; i < CORDIC_LAT; i++) begin
                qd_q[i] <= qd_q[i-1];
                vd_q[i] <= vd_q[i-1];
            end
            sin_out   <= sin_d;
            cos_out   <= cos_d;
            out_valid <= vd_q[LAST];
        end
    end

endmodule

// File: tb/tb_cordic_phase_frontend.sv
// Bench for cordic_phase_frontend: behavioural CORDIC core model, phase model
// and scoreboard of ideal full-circle sin/cos with launch-cycle tags.
module tb_cordic_phase_frontend;

    localparam int CORDIC_LAT = 7;
    localparam int TOL        = 64;
    localparam real PI        = 3.14159265358979323846;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic [15:0]        freq_word;
    logic [15:0]        phase_offset;
    logic signed [16:0] beta_out;
    logic signed [16:0] core_sin;
    logic signed [16:0] core_cos;
    logic signed [16:0] sin_out;
    logic signed [16:0] cos_out;
    logic               out_valid;

    cordic_phase_frontend #(.CORDIC_LAT(CORDIC_LAT), .DITHER_BITS(4)) dut (
        .clk(clk), .rst(rst), .en(en),
        .freq_word(freq_word), .phase_offset(phase_offset),
        .beta_out(beta_out), .core_sin(core_sin), .core_cos(core_cos),
        .sin_out(sin_out), .cos_out(cos_out), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int nvalid = 0;

    typedef struct { int s; int c; int cyc; } exp_t;
    exp_t sb[$];

    function automatic int iround(input real x);
        return (x >= 0.0) ? $rtoi(x + 0.5) : $rtoi(x - 0.5);
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_tol(input string tag, input int obs, input int exp);
        int d;
        d = (obs > exp) ? obs - exp : exp - obs;
        tests++;
        assert ((d <= TOL) === 1'b1) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d (+-%0d)", tag, obs, exp, TOL);
        end
    endtask

    // Core model: ideal sin/cos of beta, CORDIC_LAT register stages deep
    logic signed [16:0] cs_s [CORDIC_LAT];
    logic signed [16:0] cs_c [CORDIC_LAT];
    initial for (int i = 0; i < CORDIC_LAT; i++) begin cs_s[i] = '0; cs_c[i] = '0; end

    always @(posedge clk) begin
        real a;
        a = real'(beta_out) / 32768.0;
        cs_s[0] <= 17'(iround(32768.0 * $sin(a)));
        cs_c[0] <= 17'(iround(32768.0 * $cos(a)));
        for (int i = 1; i < CORDIC_LAT; i++) begin
            cs_s[i] <= cs_s[i-1];
            cs_c[i] <= cs_c[i-1];
        end
    end
    assign core_sin = cs_s[CORDIC_LAT-1];
    assign core_cos = cs_c[CORDIC_LAT-1];

    // Phase model: push expectation when the sample's phase is formed
    logic [15:0] macc = '0;
    bit          pend = 1'b0;
    bit          beta_chk = 1'b0;
    int          exp_beta = 0;

    always @(posedge clk) begin
        logic [15:0] p, s;
        int rr;
        real ang;
        exp_t e;
        cyc = cyc + 1;
        beta_chk = 1'b0;
        if (rst) begin
            macc = '0;
            pend = 1'b0;
            sb.delete();
        end else begin
            if (pend) begin
                p   = macc + phase_offset;
                ang = 2.0 * PI * real'(p) / 65536.0;
                e.s = iround(32768.0 * $sin(ang));
                e.c = iround(32768.0 * $cos(ang));
                e.cyc = cyc - 1;
                sb.push_back(e);
                s  = p + 16'h2000;
                rr = int'(s[13:0]) - 8192;
                exp_beta = (rr * 25736) >>> 13;
                beta_chk = 1'b1;
            end
            pend = en;
            if (en) macc = macc + freq_word;
        end
    end

    // Monitor: check residual angle and scoreboard on the falling edge
    always @(negedge clk) begin
        exp_t e;
        if (beta_chk) chk("beta", int'(beta_out), exp_beta);
        if (out_valid === 1'b1) begin
            nvalid++;
            if (sb.size() == 0) begin
                chk("spurious_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("latency", cyc - e.cyc, CORDIC_LAT + 2);
                chk_tol("sin", int'(sin_out), e.s);
                chk_tol("cos", int'(cos_out), e.c);
            end
        end
    end

    task automatic launch(input logic [15:0] f, input logic [15:0] off, input int eb);
        freq_word = f;
        phase_offset = off;
        en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        @(posedge clk); #1;
        chk("beta_e1", int'(beta_out), eb);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("drain", sb.size(), 0);
    endtask

    initial begin
        int nv0;
        rst = 1'b1; en = 1'b0; freq_word = '0; phase_offset = '0;
        repeat (3) @(posedge clk); #1;
        chk("rst_beta", int'(beta_out), 0);
        chk("rst_sin", int'(sin_out), 0);
        chk("rst_cos", int'(cos_out), 0);
        chk("rst_valid", int'(out_valid), 0);
        rst = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Cardinal and octant angles
        launch(16'h0000, 16'h0000, 0);      wait_drain();
        launch(16'h0000, 16'h4000, 0);      wait_drain();
        launch(16'h0000, 16'h2000, -25736); wait_drain();
        launch(16'h0000, 16'hC000, 0);      wait_drain();
        launch(16'h0000, 16'h8000, 0);      wait_drain();

        // Accumulator wrap: 0xFFF0 then +0x0020 -> 0x0010
        launch(16'hFFF0, 16'h0000, -51);
        launch(16'h0020, 16'h0000, 50);
        wait_drain();

        // Continuous stream, one full 64-sample period plus margin
        nv0 = nvalid;
        freq_word = 16'h0400; phase_offset = 16'h0000; en = 1'b1;
        repeat (70) @(posedge clk);
        #1 en = 1'b0;
        wait_drain();
        chk("stream_count", nvalid - nv0, 70);

        // Reset mid-stream drops all in-flight samples
        nv0 = nvalid;
        freq_word = 16'h1234; en = 1'b1;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0; en = 1'b0;
        repeat (15) @(posedge clk);
        #1 chk("rst_drop", nvalid - nv0, 0);

        nv0 = nvalid;
        launch(16'h0000, 16'h0000, 0);
        wait_drain();
        chk("post_rst_count", nvalid - nv0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
